// File: rtl/dec_arbiter.sv
// dec_arbiter: round-robin arbiter that drives a 4-to-16 decoder's W/En for HOLD cycles per grant
module dec_arbiter #(
  parameter int HOLD = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] Req,
  input  logic [3:0] Addr0,
  input  logic [3:0] Addr1,
  input  logic [3:0] Addr2,
  input  logic [3:0] Addr3,
  output logic [3:0] W,
  output logic       En,
  output logic [3:0] Gnt,
  output logic       Done
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);
  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d, win_q, win_d, pick, idx;
  logic [3:0] cnt_q, cnt_d, w_q, w_d, gnt_q, gnt_d, pick_addr;
  logic       en_q, en_d, done_q, done_d, found;
  // first requester found scanning from ptr upward, wrapping mod 4
  always_comb begin
    pick  = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && Req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    pick_addr = pick == 2'd0 ? Addr0 : pick == 2'd1 ? Addr1 : pick == 2'd2 ? Addr2 : Addr3;
  end
  // grant on an idle edge, count the hold window down, release with one idle cycle after Done
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    gnt_d   = gnt_q;
    en_d    = en_q;
    done_d  = done_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BUSY;
        win_d   = pick;
        gnt_d   = 4'b0001 << pick;
        w_d     = pick_addr;
        en_d    = 1'b1;
        cnt_d   = HOLD_M1;
        done_d  = HOLD_M1 == 4'd0;
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d  = cnt_q - 4'd1;
      done_d = cnt_q == 4'd1;
    end else begin
      state_d = IDLE;
      en_d    = 1'b0;
      gnt_d   = 4'b0000;
      done_d  = 1'b0;
      ptr_d   = win_q + 2'd1;
    end
  end
  // state and registered outputs; reset cancels any grant in flight
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end
  assign W    = w_q;
  assign En   = en_q;
  assign Gnt  = gnt_q;
  assign Done = done_q;
endmodule

// File: doc/dec_arbiter.md
DEC_ARBITER -- requirements
Module: dec_arbiter

Interface
REQ-001 Parameter: HOLD, 4, cycles En stays asserted per grant; legal range 1..15.
REQ-002 Port: Clock  input  1  rising-edge clock.
REQ-003 Port: Resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: Req  input  4  request, bit i = requester i; held high until that requester sees Done.
REQ-005 Port: Addr0, Addr1, Addr2, Addr3  input  4 each  target decoder line index of requester 0..3.
REQ-006 Port: W  output  4  registered decoder select, drives the 4-to-16 decoder W input.
REQ-007 Port: En  output  1  registered decoder enable, drives the 4-to-16 decoder En input.
REQ-008 Port: Gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-009 Port: Done  output  1  one-cycle pulse in the final En cycle of a grant.

Function
REQ-010 One clock, Clock; reset is asynchronous and active-low (Resetn); all outputs and state SHALL be registered.
REQ-011 FSM states: IDLE, BUSY; no other reachable state.
REQ-012 IDLE outputs: En=0, Gnt=0000, Done=0, W holds last granted address.
REQ-013 IDLE, rising edge with Req!=0: winner = first set Req bit searching Ptr, Ptr+1, ... mod 4; go to BUSY.
REQ-014 Same edge: Gnt=one-hot(winner), W=Addr of winner sampled at that edge, En=1, Cnt=HOLD-1.
REQ-015 Latency: Req sampled at edge k yields Gnt/En/W valid after edge k; no extra cycle.
REQ-016 BUSY: W and Gnt held constant; Addr and Req changes ignored for the rest of the grant.
REQ-017 BUSY: Cnt decrements by 1 per edge while Cnt!=0.
REQ-018 Done=1 exactly in the cycle where BUSY and Cnt==0; En high exactly HOLD cycles per grant.
REQ-019 Edge leaving BUSY (Cnt==0): state=IDLE, En=0, Gnt=0000, Done=0, Ptr=(winner+1) mod 4.
REQ-020 Every grant is followed by exactly one IDLE cycle; back-to-back grants are spaced HOLD+1 cycles.
REQ-021 Grant is never aborted: Req deasserting mid-grant does not shorten it.
REQ-022 Requester still high after Done is eligible again, at lowest priority relative to the others.
REQ-023 With all four requesting continuously, service order is 0,1,2,3,0,... from reset; no starvation.
REQ-024 Req==0000 in IDLE: remain IDLE, outputs unchanged.
REQ-025 Cnt is 4 bits; HOLD outside 1..15 is unsupported and unchecked.

Reset
REQ-026 Resetn low forces immediately, independent of Clock: state=IDLE, Ptr=0, Cnt=0, W=0000, En=0, Gnt=0000, Done=0.
REQ-027 Reset asserted mid-grant cancels it; no Done; after release, arbitration restarts from Ptr=0.
REQ-028 First edge with Resetn high may grant if Req!=0.

Verification
REQ-029 Single: HOLD=4, Req=0100, Addr2=1010 at edge k -> Gnt=0100, W=1010, En=1 for edges k..k+3, Done high in 4th cycle, IDLE after k+4.
REQ-030 Round-robin: Req=1111 held, HOLD=2 -> Gnt sequence 0001,0010,0100,1000,0001, each 2 cycles, 1 idle cycle between.
REQ-031 Pointer skip: after serving requester 1, Req=0011 -> next grant Gnt=0001 (requester 0), not 0010.
REQ-032 Mid-grant changes: during grant to requester 3 (Addr3=1111) change Addr3 to 0000 and drop Req -> W stays 1111, En stays HOLD cycles.
REQ-033 Reset mid-grant: Resetn low during BUSY cycle 2 -> En=0, Gnt=0000 without clock edge; after release with Req=1010 -> Gnt=0010.
REQ-034 HOLD=1: Req=0001 -> En and Done both high for exactly one cycle, then IDLE.
